// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - captures an NxN int32 result matrix and drains it one row per beat
// Each row is also offered as saturated int8 after an arithmetic right shift.
module systolic_result_drain #(
    parameter int N     = 8,
    parameter int SHIFT = 0
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic [N*N*32-1:0]      i_c,
    input  logic                   i_validResult,
    output logic [N*32-1:0]        o_row,
    output logic [N*8-1:0]         o_rowQ,
    output logic [$clog2(N)-1:0]   o_rowIdx,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_overflow,
    output logic [7:0]             o_dropCount,
    input  logic                   i_clrOverflow
);

    localparam int                 IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);

    if (N < 3 || N > 256) begin : g_bad_n
        $error("systolic_result_drain: N must be in 3..256");
    end
    if (SHIFT < 0 || SHIFT > 31) begin : g_bad_shift
        $error("systolic_result_drain: SHIFT must be in 0..31");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N*N*32-1:0]    buf_q, buf_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           cnt_q, cnt_d;

    logic                 xfer;
    logic                 at_last;
    logic                 capture;
    logic                 drop;

    assign xfer    = (state_q == DRAIN) && i_ready;
    assign at_last = (idx_q == LAST_IDX);

    // A pulse is taken when idle, or when it lands on the final beat so the next matrix follows without a bubble.
    assign capture = i_validResult && ((state_q == IDLE) || (xfer && at_last));
    assign drop    = i_validResult && !capture;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        if (capture) begin
            buf_d   = i_c;
            idx_d   = '0;
            state_d = DRAIN;
        end else if (xfer) begin
            if (at_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (i_clrOverflow) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_row       = buf_q[int'(idx_q)*N*32 +: N*32];
    assign o_rowIdx    = idx_q;
    assign o_valid     = (state_q == DRAIN);
    assign o_busy      = (state_q == DRAIN);
    assign o_last      = (state_q == DRAIN) && at_last;
    assign o_overflow  = ovf_q;
    assign o_dropCount = cnt_q;

    for (genvar c = 0; c < N; c++) begin : g_quant
        logic signed [31:0] elem;
        logic signed [31:0] shifted;

        assign elem    = o_row[c*32 +: 32];
        assign shifted = elem >>> SHIFT;
        assign o_rowQ[c*8 +: 8] = (shifted > 32'sd127)  ? 8'h7F :
                                  (shifted < -32'sd128) ? 8'h80 :
                                  shifted[7:0];
    end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameter: N, default 8, matrix dimension; legal range 3..256; elaboration error outside it.
REQ-002 Parameter: SHIFT, default 0, arithmetic right-shift applied before int8 requantisation; legal range 0..31.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_arst  input  1  reset; asynchronous and active-high.
REQ-005 i_c  input  N*N*32  signed result matrix from the systolic array, row-major [row][col].
REQ-006 i_validResult  input  1  single-cycle pulse; i_c is valid in this cycle only.
REQ-007 o_row  output  N*32  signed row currently offered.
REQ-008 o_rowQ  output  N*8  signed int8 requantised copy of o_row.
REQ-009 o_rowIdx  output  clog2(N)  index of the row on o_row.
REQ-010 o_valid  output  1  row beat valid.
REQ-011 i_ready  input  1  downstream accepts the beat.
REQ-012 o_last  output  1  high with the beat for row N-1.
REQ-013 o_busy  output  1  high while the block holds an undrained matrix.
REQ-014 o_overflow  output  1  sticky: a result pulse was dropped.
REQ-015 o_dropCount  output  8  count of dropped result pulses; saturates at 255.
REQ-016 i_clrOverflow  input  1  synchronous clear of o_overflow and o_dropCount.

Function
REQ-017 FSM states: IDLE, DRAIN.
- IDLE -> DRAIN on i_validResult.
- DRAIN -> IDLE on the accepted beat of row N-1, unless REQ-021 applies.
REQ-018 Capture: in IDLE, i_validResult registers all of i_c into an internal N*N*32 buffer and sets the row index to 0.
- o_valid rises the following cycle.
- Latency from pulse to first beat: 1 cycle.
REQ-019 Handshake: a beat transfers when o_valid && i_ready.
- o_row, o_rowQ, o_rowIdx and o_last hold stable while o_valid && !i_ready.
- o_valid does not drop until the beat transfers.
REQ-020 Each transfer advances the row index by 1; rows are emitted 0..N-1, once each, in order.
- N beats per matrix.
- Throughput with i_ready held high: 1 row per cycle.
REQ-021 Back-to-back: if i_validResult coincides with the transfer of row N-1, the new matrix is captured, the state stays DRAIN with index 0, and o_valid stays high with no bubble.
REQ-022 Drop: i_validResult in DRAIN, other than the REQ-021 case, does not alter the buffer or the index.
- Sets o_overflow.
- Increments o_dropCount, saturating at 255.
REQ-023 If i_clrOverflow coincides with a drop, the clear wins.
- Next cycle: o_overflow = 0 and o_dropCount = 0.
REQ-024 Requantisation of each element of o_rowQ, combinational from o_row:
- q = row element arithmetic-shifted right by SHIFT (floor toward minus infinity).
- Saturate q to [-128, 127].
REQ-025 o_busy = (state == DRAIN).
REQ-026 i_ready is ignored while o_valid = 0.

Reset
REQ-027 While i_arst is high:
- State = IDLE; o_valid, o_last, o_busy, o_overflow = 0.
- o_dropCount = 0; o_rowIdx = 0; o_row and o_rowQ = 0; buffer cleared.
REQ-028 Reset asserted mid-drain abandons the matrix immediately.
- No further beats after deassertion until a new i_validResult arrives.

Verification (N=4)
REQ-029 SHIFT=0, i_c[r][c] = 10*r + c, pulse, i_ready=1 -> beats on 4 consecutive cycles starting 1 cycle after the pulse; row 2 = {20,21,22,23}; o_last only on beat 3; then o_busy = 0.
REQ-030 i_ready toggles 1,0,0,1 in a repeating pattern -> all 4 rows delivered exactly once, in order, and stable while stalled.
REQ-031 Second pulse during the drain of row 1 -> that pulse is dropped, o_overflow = 1, o_dropCount = 1, and the first matrix completes unchanged; i_clrOverflow -> both return to 0.
REQ-032 Second pulse in the same cycle as the row-3 transfer -> no idle cycle, and the next beat is row 0 of the new matrix.
REQ-033 SHIFT=4, elements {-5000, 2047, 100, -17} -> o_rowQ = {-128, 127, 6, -2}.
REQ-034 i_arst pulse while row 2 is stalled -> o_valid = 0 immediately and stays 0 until the next i_validResult.
